// File: rtl/temp_spi_pkg.sv
// Shared types and constants for the multi-channel LM71-style temperature scanner.
// Optional alarm logic (TEMP_ALARM_EN) uses the alarm_next helper defined here.
package temp_spi_pkg;

   localparam int unsigned TEMP_W     = 14;
   localparam int unsigned TEMP_WX    = TEMP_W + 1;
   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned SETUP_DIVS = 1;
   localparam int unsigned HOLD_DIVS  = 1;
   localparam int unsigned GAP_DIVS   = 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   typedef logic signed [TEMP_W-1:0] temp_t;

   // Hysteretic over-temperature update; one bit wider so thresh - hyst never wraps.
   function automatic logic alarm_next(input logic cur, input temp_t s, input temp_t th,
                                       input int unsigned hyst);
      logic signed [TEMP_WX-1:0] s_w;
      logic signed [TEMP_WX-1:0] hi_w;
      logic signed [TEMP_WX-1:0] lo_w;
      s_w  = {s[TEMP_W-1], s};
      hi_w = {th[TEMP_W-1], th};
      lo_w = hi_w - $signed(TEMP_WX'(hyst));
      if (s_w > hi_w) begin
         return 1'b1;
      end else if (s_w < lo_w) begin
         return 1'b0;
      end
      return cur;
   endfunction

endpackage

// File: rtl/spi3w_rx.sv
// One 16-bit read frame on a 3-wire SPI link: SC generation, half-period counter
// and MSB-first shift register. go starts the first SC rise; done_c flags the final SC fall.
module spi3w_rx
   import temp_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  go,
   input  logic                  sio,
   output logic                  sc,
   output logic                  done_c,
   output logic [FRAME_BITS-1:0] data
);

   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned HALF_W = $clog2(2 * FRAME_BITS);
   localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME_BITS - 2);
   localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);

   logic                  active_q, active_d;
   logic                  sc_q, sc_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [HALF_W-1:0]     half_q, half_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         sc_q     <= 1'b0;
         div_q    <= '0;
         half_q   <= '0;
         shift_q  <= '0;
      end else begin
         active_q <= active_d;
         sc_q     <= sc_d;
         div_q    <= div_d;
         half_q   <= half_d;
         shift_q  <= shift_d;
      end
   end

   // SIO is captured on the same clk edge that drives SC 0->1.
   always_comb begin
      active_d = active_q;
      sc_d     = sc_q;
      div_d    = div_q;
      half_d   = half_q;
      shift_d  = shift_q;
      if (go) begin
         active_d = 1'b1;
         sc_d     = 1'b1;
         div_d    = DIV_LOAD;
         half_d   = '0;
         shift_d  = {shift_q[FRAME_BITS-2:0], sio};
      end else if (active_q) begin
         if (div_q != '0) begin
            div_d = div_q - DIV_W'(1);
         end else begin
            div_d  = DIV_LOAD;
            half_d = half_q + HALF_W'(1);
            sc_d   = ~sc_q;
            if (!sc_q) begin
               shift_d = {shift_q[FRAME_BITS-2:0], sio};
            end
            if (half_q == LAST_HALF) begin
               active_d = 1'b0;
               sc_d     = 1'b0;
            end
         end
      end
   end

   assign done_c = active_q && (div_q == '0) && (half_q == LAST_HALF);
   assign sc     = sc_q;
   assign data   = shift_q;

endmodule

// File: rtl/temp_spi_scan.sv
// Scans NUM_CH LM71-style sensors sharing SC/SIO, keeping the latest reading per channel.
// Define TEMP_ALARM_EN to build the per-channel hysteretic over-temperature alarms.
module temp_spi_scan
   import temp_spi_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CLK_DIV     = 25,
   parameter int unsigned SCAN_PERIOD = 5000000,
   parameter int unsigned HYST        = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       scan_en,
   input  logic signed [TEMP_W-1:0]   thresh_hi,
   output logic                       busy,
   output logic [NUM_CH-1:0]          cs_n,
   output logic                       sc,
   inout  wire                        sio,
   output logic [TEMP_W*NUM_CH-1:0]   temp_data,
   output logic                       sample_valid,
   output logic [2:0]                 sample_ch,
   output logic [NUM_CH-1:0]          alarm
);

   localparam int unsigned CH_W  = 3;
   localparam int unsigned TMR_W = $clog2(CLK_DIV * (SETUP_DIVS + HOLD_DIVS + GAP_DIVS));
   localparam int unsigned PER_W = $clog2(SCAN_PERIOD + 1);

   state_e                  state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [PER_W-1:0]        per_q, per_d;
   logic                    busy_q, busy_d;
   logic [NUM_CH-1:0]       cs_n_q, cs_n_d;
   logic                    sv_q, sv_d;
   logic [CH_W-1:0]         sch_q, sch_d;
   temp_t [NUM_CH-1:0]      temp_q, temp_d;
   logic [NUM_CH-1:0]       alarm_q, alarm_d;

   logic                    go_c;
   logic                    rx_done_c;
   logic                    scan_req_c;
   logic [FRAME_BITS-1:0]   rx_data;
   temp_t                   sample_c;
   logic                    unused_lsbs;

   spi3w_rx #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go_c),
      .sio     (sio),
      .sc      (sc),
      .done_c  (rx_done_c),
      .data    (rx_data)
   );

   assign sample_c    = rx_data[FRAME_BITS-1:FRAME_BITS-TEMP_W];
   assign unused_lsbs = ^rx_data[FRAME_BITS-TEMP_W-1:0];
   assign scan_req_c  = start || (scan_en && (per_q == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         tmr_q   <= '0;
         per_q   <= '0;
         busy_q  <= 1'b0;
         cs_n_q  <= '1;
         sv_q    <= 1'b0;
         sch_q   <= '0;
         temp_q  <= '0;
         alarm_q <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         tmr_q   <= tmr_d;
         per_q   <= per_d;
         busy_q  <= busy_d;
         cs_n_q  <= cs_n_d;
         sv_q    <= sv_d;
         sch_q   <= sch_d;
         temp_q  <= temp_d;
         alarm_q <= alarm_d;
      end
   end

   // Outputs are decoded from the next state so they flop in step with state_q.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      tmr_d   = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
      per_d   = (per_q != '0) ? per_q - PER_W'(1) : '0;
      busy_d  = busy_q;
      sv_d    = 1'b0;
      sch_d   = sch_q;
      temp_d  = temp_q;
      go_c    = 1'b0;
`ifdef TEMP_ALARM_EN
      alarm_d = alarm_q;
`else
      alarm_d = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (scan_req_c) begin
               state_d = SETUP;
               ch_d    = '0;
               tmr_d   = TMR_W'(SETUP_DIVS * CLK_DIV - 1);
               per_d   = PER_W'(SCAN_PERIOD - 1);
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            if (tmr_q == '0) begin
               state_d = SHIFT;
               go_c    = 1'b1;
            end
         end
         SHIFT: begin
            if (rx_done_c) begin
               state_d = HOLD;
               tmr_d   = TMR_W'(HOLD_DIVS * CLK_DIV - 1);
            end
         end
         HOLD: begin
            if (tmr_q == '0) begin
               state_d = GAP;
               tmr_d   = TMR_W'(GAP_DIVS * CLK_DIV - 1);
               sv_d    = 1'b1;
               sch_d   = ch_q;
               for (int i = 0; i < NUM_CH; i++) begin
                  if (CH_W'(i) == ch_q) begin
                     temp_d[i] = sample_c;
`ifdef TEMP_ALARM_EN
                     alarm_d[i] = alarm_next(alarm_q[i], sample_c, thresh_hi, HYST);
`endif
                  end
               end
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               if (ch_q == CH_W'(NUM_CH - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = SETUP;
                  ch_d    = ch_q + CH_W'(1);
                  tmr_d   = TMR_W'(SETUP_DIVS * CLK_DIV - 1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      cs_n_d = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((CH_W'(i) == ch_d) && (state_d == SETUP || state_d == SHIFT || state_d == HOLD)) begin
            cs_n_d[i] = 1'b0;
         end
      end
   end

`ifndef TEMP_ALARM_EN
   logic unused_thresh;
   assign unused_thresh = ^{thresh_hi, 32'(HYST)};
`endif

   assign busy         = busy_q;
   assign cs_n         = cs_n_q;
   assign temp_data    = temp_q;
   assign sample_valid = sv_q;
   assign sample_ch    = sch_q;
   assign alarm        = alarm_q;

endmodule

// File: doc/temp_spi_scan.md
# temp_spi_scan

Multi-channel successor to the single LM71CIMF temperature interface. It reads NUM_CH LM71-style 3-wire SPI temperature sensors that share one SC/SIO pair, each with its own chip-select. It scans them on demand or periodically, and holds the latest signed 14-bit reading per channel. It optionally raises per-channel over-temperature alarms with hysteresis. It sits between the board sensor pins and the system PIO/CSR fabric, clocked from the 50 MHz system clock.

## Interface
- NUM_CH, 4: number of sensors; 1..8.
- CLK_DIV, 25: clk cycles per SC half-period (25 gives 1 MHz SC at 50 MHz); minimum 2.
- SCAN_PERIOD, 5000000: clk cycles between scan starts in continuous mode (100 ms at 50 MHz).
- HYST, 32: alarm hysteresis in LSBs (1 LSB = 0.03125 °C).
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; requests one scan; ignored while busy.
- scan_en  in  1  level; enables periodic scanning.
- thresh_hi  in  14  signed alarm threshold, shared by all channels.
- busy  out  1  high from first CS_n assertion until the last channel completes.
- cs_n  out  NUM_CH  per-sensor chip select, active low.
- sc  out  1  serial clock.
- sio  inout  1  serial data; always released (high-Z) by this block, read-only use.
- temp_data  out  14*NUM_CH  latest reading; channel i occupies bits [14i+13:14i].
- sample_valid  out  1  one-cycle pulse per completed channel read.
- sample_ch  out  3  channel index qualified by sample_valid.
- alarm  out  NUM_CH  per-channel over-temperature flag.

## Operation
- FSM states are IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE → SETUP: taken on a start pulse, or when scan_en=1 and the period counter has expired. Channel index is set to 0.
- SETUP: cs_n[ch]=0, sc=0 for CLK_DIV cycles.
- SHIFT: sc toggles every CLK_DIV cycles, giving 16 rising edges. SIO is sampled into a 16-bit MSB-first shift register on the clk edge that drives sc 0→1.
- HOLD: sc=0 for CLK_DIV cycles, then cs_n[ch]=1.
  - temp_data[ch] is loaded with shift[15:2], the signed 14-bit reading.
  - sample_valid=1 and sample_ch=ch, both in the cycle cs_n rises.
- GAP: all cs_n high for CLK_DIV cycles. Then ch+1 → SETUP, or, when ch=NUM_CH-1, → IDLE and busy drops.
- Period counter:
  - Restarts at each scan start and counts SCAN_PERIOD cycles.
  - If it expires during a scan, the next scan starts immediately after returning to IDLE.
  - A start pulse and counter expiry in the same cycle produce one scan.
- Deasserting scan_en mid-scan lets the current scan complete; no further periodic scans start.
- Only one cs_n is ever low at a time; sc is low whenever all cs_n are high.
- Reset (at any time, including mid-frame) forces:
  - cs_n all 1, sc=0, busy=0, sample_valid=0, sample_ch=0;
  - temp_data all 0, alarm all 0;
  - FSM to IDLE, period counter to 0 (the first periodic scan starts on the first cycle scan_en=1).

## Timing
- Let channel CS_n fall at cycle t0.
  - Rising edge k (1..16) of sc occurs at t0+(2k-1)·CLK_DIV.
  - Final fall of sc occurs at t0+32·CLK_DIV.
  - cs_n rises and sample_valid pulses at t0+33·CLK_DIV.
  - Next channel's CS_n falls at t0+34·CLK_DIV.
- A full scan takes NUM_CH·34·CLK_DIV cycles; with defaults that is 3400 cycles.
- Start-to-first-CS_n latency is 1 cycle.
- The alarm updates in the same cycle as the matching temp_data update.

## Configuration
- TEMP_ALARM_EN defined:
  - alarm[ch] sets when the new sample > thresh_hi.
  - alarm[ch] clears when the new sample < thresh_hi − HYST.
  - Otherwise alarm[ch] holds its value.
  - Comparison is signed, in 15 bits, so subtracting HYST cannot wrap.
- TEMP_ALARM_EN undefined: comparator logic is absent, alarm is tied to 0, and thresh_hi is unused. The port list is unchanged.

## Structure
- Package temp_spi_pkg holds:
  - the state enum;
  - TEMP_W=14, FRAME_BITS=16, SETUP_CYCLES/GAP factor constants;
  - the temp_t signed typedef.
- Sub-module spi3w_rx performs one 16-bit frame: SC generation, bit counter and shift register.
  - Handshake: go in, done pulse out, frame data out.
- The top level owns channel sequencing, the period counter, result storage and alarms.

## Test plan
- Reset, then one start pulse with NUM_CH=4, CLK_DIV=2 → four CS_n windows of 66 cycles each (33 per window ×2) in order 0..3. busy is high for 272 cycles. sample_ch goes 0,1,2,3.
- Sensor models return 0x0C80, 0xFFFC, 0x0003, 0x7FFC → temp_data equals 0x0320 (+25 °C), 0x3FFF (−1 LSB), 0x0000, 0x1FFF.
- scan_en=1 with SCAN_PERIOD=300 → scans start exactly 300 cycles apart. With SCAN_PERIOD=100 (less than the scan length) → back-to-back scans with one IDLE cycle between.
- TEMP_ALARM_EN, thresh_hi=0x0320, HYST=32, samples 0x0321, 0x0310, 0x02FF:
  - alarm goes 1 on 0x0321;
  - stays 1 on 0x0310;
  - goes 0 on 0x02FF.
  - Without the macro, alarm stays 0.
- Assert reset_n low during the 9th SC period → next cycle shows cs_n=all 1, sc=0, busy=0, temp_data unchanged from reset value 0. A start after release runs a clean scan.
- Start pulse while busy → ignored; scan count unchanged.
